// File: rtl/mem_loader_if.sv
// Memory write port driven by the serial loader into cpumemory (mw/addr/data_in).
interface mem_loader_if;
   logic        mw;
   logic [15:0] addr;
   logic [7:0]  data_out;

   modport master (output mw, addr, data_out);
   modport slave  (input  mw, addr, data_out);
endinterface

// File: rtl/mem_loader.sv
// Serial program loader: 8N1 UART receiver plus a frame FSM that writes the image into cpumemory.
// state  | meaning
// IDLE   | waiting for 0xA5 sync, other bytes dropped
// ADDR_H | latch start address high byte
// ADDR_L | latch start address low byte
// LEN_H  | latch length high byte
// LEN_L  | latch length low byte, skip DATA when zero
// DATA   | one write per byte, address/checksum/count step after each pulse
// CSUM   | compare checksum, pulse done or raise err
module mem_loader #(
   parameter int CLK_HZ      = 50000000,
   parameter int BAUD        = 115200,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx,
   mem_loader_if.master mem,
   output logic         busy,
   output logic         done,
   output logic         err
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int BW  = $clog2(DIV);
   localparam int TW  = $clog2(TIMEOUT_CYC);
   localparam logic [BW-1:0] HALF_LD = BW'(DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LD  = BW'(DIV - 1);
   localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM} state_t;

   logic          rx_s1, rx_s2, rx_prev, rx_fall;
   rx_state_t     rx_state, rx_nxt;
   logic [BW-1:0] baud_cnt, cnt_val;
   logic          cnt_load, shift_en, byte_valid, frame_err;
   logic [2:0]    bit_idx;
   logic [7:0]    rx_byte;

   state_t        st, st_nxt;
   logic [TW-1:0] to_cnt;
   logic [7:0]    len_h, csum, data_q;
   logic [15:0]   len_cnt, addr_q;
   logic          mw_q, take, abort, done_set, err_set, accept_sync;

   assign rx_fall = rx_prev & ~rx_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         rx_byte  <= '0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_nxt;
         if (cnt_load)
            baud_cnt <= cnt_val;
         else if (baud_cnt != '0)
            baud_cnt <= baud_cnt - 1'b1;
         if (rx_state == RX_START)
            bit_idx <= '0;
         else if (shift_en)
            bit_idx <= bit_idx + 1'b1;
         if (shift_en)
            rx_byte <= {rx_s2, rx_byte[7:1]};
      end
   end

   always_comb begin
      rx_nxt     = rx_state;
      cnt_load   = 1'b0;
      cnt_val    = BIT_LD;
      shift_en   = 1'b0;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (rx_state)
         RX_IDLE: if (rx_fall) begin
            rx_nxt   = RX_START;
            cnt_load = 1'b1;
            cnt_val  = HALF_LD;
         end
         // mid-bit re-check rejects short low glitches
         RX_START: if (baud_cnt == '0) begin
            if (!rx_s2) begin
               rx_nxt   = RX_BITS;
               cnt_load = 1'b1;
            end else begin
               rx_nxt = RX_IDLE;
            end
         end
         RX_BITS: if (baud_cnt == '0) begin
            shift_en = 1'b1;
            cnt_load = 1'b1;
            if (bit_idx == 3'd7) rx_nxt = RX_STOP;
         end
         RX_STOP: if (baud_cnt == '0) begin
            rx_nxt     = RX_IDLE;
            byte_valid = rx_s2;
            frame_err  = ~rx_s2;
         end
         default: rx_nxt = RX_IDLE;
      endcase
   end

   always_comb begin
      st_nxt      = st;
      done_set    = 1'b0;
      err_set     = 1'b0;
      accept_sync = 1'b0;
      abort       = (st != ST_IDLE) && (frame_err || to_cnt == '0);
      take        = byte_valid && !abort;
      if (abort) begin
         st_nxt  = ST_IDLE;
         err_set = 1'b1;
      end else begin
         case (st)
            ST_IDLE: if (take && rx_byte == 8'hA5) begin
               st_nxt      = ST_ADDR_H;
               accept_sync = 1'b1;
            end
            ST_ADDR_H: if (take) st_nxt = ST_ADDR_L;
            ST_ADDR_L: if (take) st_nxt = ST_LEN_H;
            ST_LEN_H:  if (take) st_nxt = ST_LEN_L;
            ST_LEN_L:  if (take) st_nxt = ({len_h, rx_byte} == 16'h0000) ? ST_CSUM : ST_DATA;
            ST_DATA:   if (mw_q && len_cnt == 16'h0001) st_nxt = ST_CSUM;
            ST_CSUM: if (take) begin
               st_nxt   = ST_IDLE;
               done_set = (rx_byte == csum);
               err_set  = (rx_byte != csum);
            end
            default: st_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_IDLE;
         to_cnt  <= TO_LD;
         len_h   <= '0;
         len_cnt <= '0;
         csum    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         mw_q    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         st   <= st_nxt;
         done <= done_set;
         mw_q <= 1'b0;
         if (err_set)
            err <= 1'b1;
         else if (accept_sync)
            err <= 1'b0;
         if (byte_valid || st == ST_IDLE)
            to_cnt <= TO_LD;
         else if (to_cnt != '0)
            to_cnt <= to_cnt - 1'b1;
         if (accept_sync)
            csum <= '0;
         if (take) begin
            case (st)
               ST_ADDR_H: addr_q[15:8] <= rx_byte;
               ST_ADDR_L: addr_q[7:0]  <= rx_byte;
               ST_LEN_H:  len_h        <= rx_byte;
               ST_LEN_L:  len_cnt      <= {len_h, rx_byte};
               ST_DATA: begin
                  mw_q   <= 1'b1;
                  data_q <= rx_byte;
               end
               default: ;
            endcase
         end
         // bookkeeping runs the cycle after the strobe so the write sees the old address
         if (mw_q) begin
            addr_q  <= addr_q + 1'b1;
            csum    <= csum + data_q;
            len_cnt <= len_cnt - 1'b1;
         end
      end
   end

   assign busy         = (st != ST_IDLE);
   assign mem.mw       = mw_q;
   assign mem.addr     = addr_q;
   assign mem.data_out = data_q;
endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: frame vectors from a table, then glitch, framing, timeout and reset sequences.
module tb_mem_loader;
   logic clk, rst_n, rx;
   logic busy, done, err;
   int   n_chk, n_fail;
   int   wr_n, done_n, bad_n;
   logic [15:0] cap_a [64];
   logic [7:0]  cap_d [64];

   mem_loader_if bus ();

   mem_loader #(.CLK_HZ(160), .BAUD(10), .TIMEOUT_CYC(400)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .mem(bus),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic [0:11][7:0] seq;
      int               nbytes;
      int               sync_idx;
      int               nwr;
      logic [0:2][15:0] wa;
      logic [0:2][7:0]  wd;
      int               ndone;
      logic             err_end;
      logic [15:0]      addr_end;
   } vec_t;

   vec_t vecs [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // strobes and done pulses are captured on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mw) begin
            if (wr_n < 64) begin
               cap_a[wr_n] <= bus.addr;
               cap_d[wr_n] <= bus.data_out;
            end
            wr_n <= wr_n + 1;
            if (!busy) bad_n <= bad_n + 1;
         end
         if (done) begin
            done_n <= done_n + 1;
            if (busy) bad_n <= bad_n + 1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      step(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         step(16);
      end
      rx = stop;
      step(16);
      rx = 1'b1;
   endtask

   task automatic run_vec(input int idx);
      int bw, bd;
      bw = wr_n;
      bd = done_n;
      for (int i = 0; i < vecs[idx].nbytes; i++) begin
         send_byte(vecs[idx].seq[i], 1'b1);
         if (i == vecs[idx].sync_idx) begin
            chk($sformatf("v%0d_busy_after_sync", idx), {31'd0, busy}, 32'd1);
            chk($sformatf("v%0d_err_after_sync", idx), {31'd0, err}, 32'd0);
         end
      end
      step(20);
      chk($sformatf("v%0d_write_count", idx), wr_n - bw, vecs[idx].nwr);
      for (int k = 0; k < vecs[idx].nwr; k++) begin
         if (bw + k < wr_n && bw + k < 64) begin
            chk($sformatf("v%0d_wr%0d_addr", idx, k), {16'd0, cap_a[bw + k]}, {16'd0, vecs[idx].wa[k]});
            chk($sformatf("v%0d_wr%0d_data", idx, k), {24'd0, cap_d[bw + k]}, {24'd0, vecs[idx].wd[k]});
         end
      end
      chk($sformatf("v%0d_done_count", idx), done_n - bd, vecs[idx].ndone);
      chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, vecs[idx].err_end});
      chk($sformatf("v%0d_busy_end", idx), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_addr_end", idx), {16'd0, bus.addr}, {16'd0, vecs[idx].addr_end});
   endtask

   initial begin
      int bw, bd, n;
      n_chk = 0; n_fail = 0;
      wr_n = 0; done_n = 0; bad_n = 0;
      rx = 1'b1;
      rst_n = 1'b0;

      vecs[0] = '{seq: {8'hA5,8'h00,8'h10,8'h00,8'h03,8'h11,8'h22,8'h33,8'h66,8'h00,8'h00,8'h00}, nbytes: 9, sync_idx: 0,
                  nwr: 3, wa: {16'h0010,16'h0011,16'h0012}, wd: {8'h11,8'h22,8'h33}, ndone: 1, err_end: 1'b0, addr_end: 16'h0013};
      vecs[1] = '{seq: {8'hA5,8'h00,8'h10,8'h00,8'h03,8'h11,8'h22,8'h33,8'h67,8'h00,8'h00,8'h00}, nbytes: 9, sync_idx: 0,
                  nwr: 3, wa: {16'h0010,16'h0011,16'h0012}, wd: {8'h11,8'h22,8'h33}, ndone: 0, err_end: 1'b1, addr_end: 16'h0013};
      vecs[2] = '{seq: {8'hA5,8'hFF,8'hFF,8'h00,8'h02,8'h01,8'h02,8'h03,8'h00,8'h00,8'h00,8'h00}, nbytes: 8, sync_idx: 0,
                  nwr: 2, wa: {16'hFFFF,16'h0000,16'h0000}, wd: {8'h01,8'h02,8'h00}, ndone: 1, err_end: 1'b0, addr_end: 16'h0001};
      vecs[3] = '{seq: {8'hA5,8'h12,8'h34,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, nbytes: 6, sync_idx: 0,
                  nwr: 0, wa: {16'h0,16'h0,16'h0}, wd: {8'h0,8'h0,8'h0}, ndone: 1, err_end: 1'b0, addr_end: 16'h1234};
      vecs[4] = '{seq: {8'hA5,8'h00,8'h20,8'h00,8'h02,8'hA5,8'h01,8'hA6,8'h00,8'h00,8'h00,8'h00}, nbytes: 8, sync_idx: 0,
                  nwr: 2, wa: {16'h0020,16'h0021,16'h0}, wd: {8'hA5,8'h01,8'h00}, ndone: 1, err_end: 1'b0, addr_end: 16'h0022};
      vecs[5] = '{seq: {8'h3C,8'hA5,8'h00,8'h30,8'h00,8'h01,8'h7F,8'h7F,8'h00,8'h00,8'h00,8'h00}, nbytes: 8, sync_idx: 1,
                  nwr: 1, wa: {16'h0030,16'h0,16'h0}, wd: {8'h7F,8'h00,8'h00}, ndone: 1, err_end: 1'b0, addr_end: 16'h0031};
      vecs[6] = '{seq: {8'hA5,8'h00,8'h40,8'h00,8'h01,8'h5A,8'h5A,8'h00,8'h00,8'h00,8'h00,8'h00}, nbytes: 7, sync_idx: 0,
                  nwr: 1, wa: {16'h0040,16'h0,16'h0}, wd: {8'h5A,8'h00,8'h00}, ndone: 1, err_end: 1'b0, addr_end: 16'h0041};
      vecs[7] = '{seq: {8'hA5,8'h00,8'h60,8'h00,8'h01,8'h42,8'h42,8'h00,8'h00,8'h00,8'h00,8'h00}, nbytes: 7, sync_idx: 0,
                  nwr: 1, wa: {16'h0060,16'h0,16'h0}, wd: {8'h42,8'h00,8'h00}, ndone: 1, err_end: 1'b0, addr_end: 16'h0061};

      step(3);
      chk("reset_mw", {31'd0, bus.mw}, 32'd0);
      chk("reset_addr", {16'd0, bus.addr}, 32'd0);
      chk("reset_data", {24'd0, bus.data_out}, 32'd0);
      chk("reset_busy_done_err", {29'd0, busy, done, err}, 32'd0);
      rst_n = 1'b1;
      step(5);

      for (int v = 0; v < 6; v++) run_vec(v);

      // short low glitch in IDLE, immediately followed by a real frame
      rx = 1'b0;
      step(4);
      rx = 1'b1;
      step(8);
      chk("glitch_busy", {31'd0, busy}, 32'd0);
      run_vec(6);

      // framing error after A5 00
      bw = wr_n;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h55, 1'b0);
      step(5);
      chk("frame_err_err", {31'd0, err}, 32'd1);
      chk("frame_err_busy", {31'd0, busy}, 32'd0);
      chk("frame_err_no_write", wr_n - bw, 32'd0);
      step(30);

      // stalled frame must time out
      bw = wr_n;
      bd = done_n;
      send_byte(8'hA5, 1'b1);
      chk("to_err_cleared", {31'd0, err}, 32'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      n = 0;
      while (!err && n < 450) begin
         step(1);
         n++;
      end
      chk("to_err_set", {31'd0, err}, 32'd1);
      chk("to_latency_window", {31'd0, (n >= 380 && n <= 420)}, 32'd1);
      chk("to_busy", {31'd0, busy}, 32'd0);
      chk("to_one_write", wr_n - bw, 32'd1);
      chk("to_no_done", done_n - bd, 32'd0);
      step(10);

      // reset in the middle of DATA
      bw = wr_n;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h50, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      chk("rst_mid_writes_before", wr_n - bw, 32'd2);
      chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_mw", {31'd0, bus.mw}, 32'd0);
      chk("rst_mid_addr", {16'd0, bus.addr}, 32'd0);
      chk("rst_mid_data", {24'd0, bus.data_out}, 32'd0);
      chk("rst_mid_busy_done_err", {29'd0, busy, done, err}, 32'd0);
      step(3);
      rst_n = 1'b1;
      step(5);
      run_vec(7);

      chk("mw_outside_busy_or_done_with_busy", bad_n, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
